i2s_audio_tx: RTL and testbench



---
 rtl/audio_pkg.sv | 13 +
 rtl/i2s_bck_gen.sv | 36 +++
 rtl/i2s_audio_tx.sv | 113 +++++++++++
 tb/tb_i2s_audio_tx.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared audio types and constants for the I2S transmit path.
// Holds default sample width, slot width and the stereo sample bundle.
package audio_pkg;

  localparam int SAMPLE_W  = 16;
  localparam int SLOT_BITS = 32;

  typedef struct packed {
    logic signed [SAMPLE_W-1:0] left;
    logic signed [SAMPLE_W-1:0] right;
  } stereo_sample_t;

endpackage

// File: rtl/i2s_bck_gen.sv
// I2S bit-clock generator: divides clk_sys by 2*BCK_DIV into bck.
// Ports: clk_sys, reset (sync, high) in; bck, fall_stb, rise_stb out.
module i2s_bck_gen #(
  parameter int BCK_DIV = 4
) (
  input  logic clk_sys,
  input  logic reset,
  output logic bck,
  output logic fall_stb,
  output logic rise_stb
);

  localparam int DW = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;

  logic [DW-1:0] div;
  logic          wrap;

  assign wrap = (div == DW'(BCK_DIV - 1));

  // Strobes mark the clk_sys edge on which bck toggles.
  assign fall_stb = wrap & bck;
  assign rise_stb = wrap & ~bck;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      div <= '0;
      bck <= 1'b0;
    end else if (wrap) begin
      div <= '0;
      bck <= ~bck;
    end else begin
      div <= div + 1'b1;
    end
  end

endmodule

// File: rtl/i2s_audio_tx.sv
// I2S stereo serializer with a one-deep pending sample buffer.
// Ports: clk_sys, reset, left, right, sample_valid in;
//   sample_ready, i2s_bck, i2s_lrck, i2s_data, underrun out.
// Build option I2S_LEFT_JUSTIFIED_EN: left-justified slots (no MSB delay).
module i2s_audio_tx #(
  parameter int BCK_DIV  = 4,
  parameter int SAMPLE_W = 16
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] left,
  input  logic [SAMPLE_W-1:0] right,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic                i2s_bck,
  output logic                i2s_lrck,
  output logic                i2s_data,
  output logic                underrun
);

  import audio_pkg::*;

  typedef struct packed {
    logic signed [SAMPLE_W-1:0] left;
    logic signed [SAMPLE_W-1:0] right;
  } pair_t;

  pair_t                pend;
  pair_t                active;
  pair_t                frame_src;
  logic                 pend_full;
  logic                 fall_stb;
  logic                 unused_rise;
  logic [5:0]           bitcnt;
  logic [5:0]           bit_nx;
  logic [SLOT_BITS-1:0] sh;
  logic [SLOT_BITS-1:0] ld_l;
  logic [SLOT_BITS-1:0] ld_r;

  i2s_bck_gen #(
    .BCK_DIV (BCK_DIV)
  ) u_bck (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .bck      (i2s_bck),
    .fall_stb (fall_stb),
    .rise_stb (unused_rise)
  );

  function automatic logic [SLOT_BITS-1:0] slot_word(
    input logic [SAMPLE_W-1:0] s
  );
    logic [SLOT_BITS-1:0] ext;
    ext = {{(SLOT_BITS - SAMPLE_W){1'b0}}, s};
`ifdef I2S_LEFT_JUSTIFIED_EN
    return ext << (SLOT_BITS - SAMPLE_W);
`else
    // One leading zero bit gives the standard one-BCK MSB delay.
    return ext << (SLOT_BITS - 1 - SAMPLE_W);
`endif
  endfunction

  assign sample_ready = ~pend_full;
  assign bit_nx       = bitcnt + 6'd1;

  // The left slot must see the sample being promoted this frame.
  always_comb begin
    frame_src = active;
    if (pend_full) frame_src = pend;
    ld_l = slot_word(frame_src.left);
    ld_r = slot_word(active.right);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      pend      <= '0;
      active    <= '0;
      pend_full <= 1'b0;
      bitcnt    <= '0;
      sh        <= '0;
      i2s_lrck  <= 1'b0;
      i2s_data  <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (sample_valid && sample_ready) begin
        pend      <= '{left: left, right: right};
        pend_full <= 1'b1;
      end
      if (fall_stb) begin
        bitcnt   <= bit_nx;
        i2s_lrck <= bit_nx[5];
        if (bit_nx == 6'd0) begin
          if (pend_full) begin
            active    <= pend;
            pend_full <= 1'b0;
          end else begin
            underrun <= 1'b1;
          end
          i2s_data <= ld_l[SLOT_BITS-1];
          sh       <= ld_l << 1;
        end else if (bit_nx == 6'd32) begin
          i2s_data <= ld_r[SLOT_BITS-1];
          sh       <= ld_r << 1;
        end else begin
          i2s_data <= sh[SLOT_BITS-1];
          sh       <= sh << 1;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_audio_tx.sv
// Directed bench for i2s_audio_tx at BCK_DIV=2.
// Frames are captured bit by bit on BCK falls and compared to constants.
module tb_i2s_audio_tx;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] left_s = '0;
  logic [15:0] right_s = '0;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic        i2s_bck;
  logic        i2s_lrck;
  logic        i2s_data;
  logic        underrun;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int n_xfer = 0;
  int n_ur = 0;
  int rdy_rise = -1;
  logic prev_bck, prev_lrck, prev_rdy;

  i2s_audio_tx #(
    .BCK_DIV  (2),
    .SAMPLE_W (16)
  ) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .left         (left_s),
    .right        (right_s),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .i2s_bck      (i2s_bck),
    .i2s_lrck     (i2s_lrck),
    .i2s_data     (i2s_data),
    .underrun     (underrun)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    logic hs;
    hs = sample_valid && sample_ready;
    prev_bck  = i2s_bck;
    prev_lrck = i2s_lrck;
    prev_rdy  = sample_ready;
    @(posedge clk_sys);
    #1;
    cyc++;
    if (hs) begin
      n_xfer++;
      sample_valid = 1'b0;
    end
    if (underrun === 1'b1) n_ur++;
    if (prev_rdy === 1'b0 && sample_ready === 1'b1) rdy_rise = cyc;
  endtask

  task automatic push(input logic [15:0] l, input logic [15:0] r);
    left_s = l;
    right_s = r;
    sample_valid = 1'b1;
    for (int i = 0; i < 600 && sample_valid; i++) tick();
    check("push_done", 64'(sample_valid), 64'd0);
  endtask

  task automatic wait_falls(input int k);
    int n;
    n = 0;
    for (int i = 0; i < 4 * k + 8 && n < k; i++) begin
      tick();
      if (prev_bck && !i2s_bck) n++;
    end
    check("falls_seen", 64'(n), 64'(k));
  endtask

  task automatic grab(output logic [63:0] bits,
                      output int ur, output int t0);
    logic ok;
    int n;
    ok = 1'b0;
    bits = '0;
    ur = 0;
    n = 0;
    t0 = cyc;
    for (int i = 0; i < 600 && !ok; i++) begin
      tick();
      if (prev_lrck === 1'b1 && i2s_lrck === 1'b0) ok = 1'b1;
    end
    check("frame_start", 64'(ok), 64'd1);
    if (ok) begin
      t0 = cyc;
      bits = {63'd0, i2s_data};
      if (underrun === 1'b1) ur++;
      for (int i = 0; i < 300 && n < 63; i++) begin
        tick();
        if (underrun === 1'b1) ur++;
        if (prev_bck && !i2s_bck) begin
          bits = {bits[62:0], i2s_data};
          n++;
        end
      end
      check("frame_bits", 64'(n), 64'd63);
    end
  endtask

  logic [63:0] fr;
  int ur, t0, t1, rel, x0;

  initial begin
    for (int i = 0; i < 3; i++) tick();
    reset = 1'b0;
    rel = cyc;
    check("rst_bck",   64'(i2s_bck),      64'd0);
    check("rst_lrck",  64'(i2s_lrck),     64'd0);
    check("rst_data",  64'(i2s_data),     64'd0);
    check("rst_ur",    64'(underrun),     64'd0);
    check("rst_ready", 64'(sample_ready), 64'd1);

    t0 = -1;
    for (int i = 0; i < 10 && t0 < 0; i++) begin
      tick();
      if (i2s_bck) t0 = cyc - rel;
    end
    check("first_rise", 64'(t0), 64'd2);
    t1 = -1;
    for (int i = 0; i < 10 && t1 < 0; i++) begin
      tick();
      if (!i2s_bck) t1 = cyc - rel;
    end
    check("first_fall", 64'(t1), 64'd4);

    // single sample
    push(16'hA5C3, 16'h0F0F);
    check("ready_low", 64'(sample_ready), 64'd0);
    grab(fr, ur, t0);
    check("f1_time", 64'(t0 - rel), 64'd256);
    check("f1_data", fr, 64'h52E18000_07878000);
    check("f1_ur",   64'(ur), 64'd0);
    check("no_ur_reset_frame", 64'(n_ur), 64'd0);
    check("ready_back", 64'(sample_ready), 64'd1);

    // starvation
    grab(fr, ur, t1);
    check("lrck_period", 64'(t1 - t0), 64'd256);
    check("f2_data", fr, 64'h52E18000_07878000);
    check("f2_ur",   64'(ur), 64'd1);

    // backpressure
    x0 = n_xfer;
    push(16'h1111, 16'h2222);
    check("bp_ready_low", 64'(sample_ready), 64'd0);
    rdy_rise = -1;
    left_s = 16'h3333;
    right_s = 16'h4444;
    sample_valid = 1'b1;
    grab(fr, ur, t0);
    check("bp_fa_data", fr, 64'h08888000_11110000);
    check("bp_fa_ur",   64'(ur), 64'd0);
    check("bp_rdy_rise", 64'(rdy_rise), 64'(t0));
    check("bp_xfers", 64'(n_xfer - x0), 64'd2);
    check("bp_b_pending", 64'(sample_ready), 64'd0);
    grab(fr, ur, t0);
    check("bp_fb_data", fr, 64'h19998000_22220000);
    check("bp_fb_ur",   64'(ur), 64'd0);
    grab(fr, ur, t0);
    check("bp_rep_data", fr, 64'h19998000_22220000);
    check("bp_rep_ur",   64'(ur), 64'd1);

    // handshake on the frame-start edge
    for (int i = 0; i < 3; i++) tick();
    left_s = 16'h5555;
    right_s = 16'h6666;
    sample_valid = 1'b1;
    grab(fr, ur, t0);
    check("sim_old_data", fr, 64'h19998000_22220000);
    check("sim_ur", 64'(ur), 64'd1);
    check("sim_pending", 64'(sample_ready), 64'd0);
    grab(fr, ur, t0);
    check("sim_new_data", fr, 64'h2AAA8000_33330000);
    check("sim_new_ur", 64'(ur), 64'd0);

    // reset at bitcnt 40 with a sample pending
    wait_falls(1);
    push(16'h7777, 16'h0123);
    wait_falls(40);
    check("mid_lrck", 64'(i2s_lrck), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rel = cyc;
    check("mr_bck",   64'(i2s_bck),      64'd0);
    check("mr_lrck",  64'(i2s_lrck),     64'd0);
    check("mr_data",  64'(i2s_data),     64'd0);
    check("mr_ur",    64'(underrun),     64'd0);
    check("mr_ready", 64'(sample_ready), 64'd1);
    grab(fr, ur, t0);
    check("mr_time", 64'(t0 - rel), 64'd256);
    check("mr_data_zero", fr, 64'd0);
    check("mr_ur_frame", 64'(ur), 64'd1);

    // format of a sample with both end bits set
    push(16'h8001, 16'h8001);
    grab(fr, ur, t0);
`ifdef I2S_LEFT_JUSTIFIED_EN
    check("fmt_8001", fr, 64'h80010000_80010000);
    check("fmt_msb_at_lrck", 64'(fr[63]), 64'd1);
`else
    check("fmt_8001", fr, 64'h40008000_40008000);
    check("fmt_msb_at_lrck", 64'(fr[63]), 64'd0);
`endif
    check("fmt_ur", 64'(ur), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
